// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// sram_ctrl_pkg : shared widths, FSM states and request record for the
//                 SRAM bank arbiter.                              Rev 1.0
// ============================================================================
package sram_ctrl_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 48;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin grant, searching upward from ptr
//              modulo NREQ. The pointer register lives in the parent. Rev 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (i == ((int'(ptr) + off) % NREQ))) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_bank_arbiter.sv
`default_nettype none
// ============================================================================
// sram_bank_arbiter : scrubs a 256x48 SRAM bank to zero after reset, then
//                     round-robin shares its single port among NREQ clients.
//                                                                  Rev 1.0
// ============================================================================
module sram_bank_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = sram_ctrl_pkg::ADDR_W,
    parameter int DATA_W = sram_ctrl_pkg::DATA_W,
    parameter int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     init_done,
    output logic [ADDR_W-1:0]        bank_address,
    output logic [DATA_W-1:0]        bank_wd,
    output logic                     bank_banksel,
    output logic                     bank_read,
    output logic                     bank_write,
    input  logic [DATA_W-1:0]        bank_dataout
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   scrub_cnt_q, scrub_cnt_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;

    logic                run;
    logic [NREQ-1:0]     live_req;
    logic [NREQ-1:0]     grant;
    logic [ID_W-1:0]     grant_idx;
    req_t                sel_req;

    assign run      = (state_q == RUN);
    assign live_req = req_valid & {NREQ{run}};

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req   (live_req),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    // Grant is one-hot, so at most one requester's fields reach the mux output.
    always_comb begin
        grant_idx = '0;
        sel_req   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx     = ID_W'(i);
                sel_req.write = req_write[i];
                sel_req.addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_req.wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        scrub_cnt_d = scrub_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            INIT: begin
                scrub_cnt_d = scrub_cnt_q + 1'b1;
                if (&scrub_cnt_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (|grant) begin
                    rr_ptr_d = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    if (!sel_req.write) begin
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = grant_idx;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            scrub_cnt_q <= '0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            scrub_cnt_q <= scrub_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // Reset gates the bank port directly so it goes quiet the moment reset rises.
    always_comb begin
        bank_banksel = 1'b0;
        bank_write   = 1'b0;
        bank_read    = 1'b0;
        bank_address = '0;
        bank_wd      = '0;
        if (!reset) begin
            if (state_q == INIT) begin
                bank_banksel = 1'b1;
                bank_write   = 1'b1;
                bank_address = scrub_cnt_q;
            end else begin
                bank_banksel = |grant;
                bank_write   = (|grant) & sel_req.write;
                bank_read    = (|grant) & ~sel_req.write;
                bank_address = sel_req.addr;
                bank_wd      = sel_req.wdata;
            end
        end
    end

    assign req_ready = grant;
    assign init_done = run;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = bank_dataout;

endmodule
`default_nettype wire

// File: tb/tb_sram_bank_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sram_bank_arbiter : scoreboard bench for sram_bank_arbiter with a
//                        behavioural registered-output bank.        Rev 1.0
// ============================================================================
module tb_sram_bank_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 8;
    localparam int DW   = 48;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_write = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic [0:0]        rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              init_done;
    logic [AW-1:0]     bank_address;
    logic [DW-1:0]     bank_wd;
    logic              bank_banksel;
    logic              bank_read;
    logic              bank_write;
    logic [DW-1:0]     bank_dataout;

    always #5 clk = ~clk;

    sram_bank_arbiter #(.NREQ(NREQ)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .init_done    (init_done),
        .bank_address (bank_address),
        .bank_wd      (bank_wd),
        .bank_banksel (bank_banksel),
        .bank_read    (bank_read),
        .bank_write   (bank_write),
        .bank_dataout (bank_dataout)
    );

    // Bank model: garbage-filled while in reset so only the scrub can zero it.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= {16'hDEAD, 24'(i), 8'h5A};
        end else if (bank_banksel) begin
            if (bank_write) mem[bank_address] <= bank_wd;
            else if (bank_read) bank_dataout <= mem[bank_address];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [0:0]    id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem [256];
    int            tb_ptr = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic model_clear();
        sb.delete();
        tb_ptr = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    endtask

    // One clock of traffic: retire a due response, then drive and check grant.
    task automatic step(input logic [1:0] v, input logic [1:0] w,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        output logic [1:0] rdy);
        exp_t e;
        int g;
        logic gw;
        logic [7:0] ga;
        logic [DW-1:0] gd;
        logic [1:0] exp_rdy;
        @(negedge clk);
        if (rsp_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: rsp_valid=1 id=%0d data=%h, required no response", rsp_id, rsp_data);
            end else begin
                e = sb.pop_front();
                if (rsp_id !== e.id || rsp_data !== e.data || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL rsp_match: got id=%0d data=%h cycle=%0d, required id=%0d data=%h cycle=%0d",
                             rsp_id, rsp_data, cyc, e.id, e.data, e.due);
                end
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_missing: rsp_valid=0 at cycle %0d, required id=%0d data=%h", cyc, sb[0].id, sb[0].data);
            void'(sb.pop_front());
        end
        req_valid = v;
        req_write = w;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        #1;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (tb_ptr + k) % NREQ;
            if (g < 0 && v[idx]) g = idx;
        end
        exp_rdy = (g < 0) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
        rdy = req_ready;
        n_checks++;
        if (req_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL req_ready: got %b, required %b", req_ready, exp_rdy);
        end
        if (g >= 0) begin
            gw = w[g];
            ga = (g == 1) ? a1 : a0;
            gd = (g == 1) ? d1 : d0;
            n_checks++;
            if ({bank_banksel, bank_write, bank_read, bank_address} !== {1'b1, gw, ~gw, ga} ||
                (gw && bank_wd !== gd)) begin
                n_fail++;
                $display("FAIL bank_drive: got sel=%b wr=%b rd=%b addr=%h wd=%h, required sel=1 wr=%b rd=%b addr=%h wd=%h",
                         bank_banksel, bank_write, bank_read, bank_address, bank_wd, gw, ~gw, ga, gd);
            end
            if (gw) ref_mem[ga] = gd;
            else sb.push_back('{id: 1'(g), data: ref_mem[ga], due: cyc + 1});
            tb_ptr = (g + 1) % NREQ;
        end else begin
            n_checks++;
            if ({bank_banksel, bank_write, bank_read} !== 3'b000) begin
                n_fail++;
                $display("FAIL bank_idle: got sel=%b wr=%b rd=%b, required 000", bank_banksel, bank_write, bank_read);
            end
        end
    endtask

    task automatic drain();
        logic [1:0] r;
        repeat (3) step(2'b00, 2'b00, 8'h00, 8'h00, '0, '0, r);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    // Releases reset and follows the scrub until init_done rises.
    task automatic run_scrub(input string tag);
        int  n;
        bit  bad;
        bad = 0;
        req_valid = 2'b11;
        req_write = 2'b00;
        reset = 1'b0;
        #1;
        n = 0;
        while (!init_done && n < 400) begin
            if (req_ready !== 2'b00 || bank_address !== n[7:0] || bank_banksel !== 1'b1 ||
                bank_write !== 1'b1 || bank_read !== 1'b0 || bank_wd !== '0) begin
                if (!bad) $display("FAIL %s_drive: cycle %0d ready=%b addr=%h sel=%b wr=%b rd=%b wd=%h, required ready=00 addr=%h sel=1 wr=1 rd=0 wd=0",
                                   tag, n, req_ready, bank_address, bank_banksel, bank_write, bank_read, bank_wd, n[7:0]);
                bad = 1;
            end
            @(negedge clk);
            n++;
        end
        req_valid = 2'b00;
        #1;
        n_checks++;
        if (bad) n_fail++;
        n_checks++;
        if (n != 256) begin
            n_fail++;
            $display("FAIL %s_len: init_done after %0d cycles, required 256", tag, n);
        end
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({init_done, req_ready, rsp_valid, rsp_id, bank_banksel, bank_read, bank_write, bank_address, bank_wd} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: init=%b ready=%b rv=%b id=%b sel=%b rd=%b wr=%b addr=%h wd=%h, required all 0",
                     init_done, req_ready, rsp_valid, rsp_id, bank_banksel, bank_read, bank_write, bank_address, bank_wd);
        end
        run_scrub("scrub");
    endtask

    task automatic test_scrub_read();
        logic [1:0] r;
        step(2'b01, 2'b00, 8'h05, 8'h00, '0, '0, r);
        drain();
    endtask

    task automatic test_write_read();
        logic [1:0] r;
        step(2'b01, 2'b01, 8'h10, 8'h00, 48'h123456789ABC, '0, r);
        step(2'b01, 2'b00, 8'h10, 8'h00, '0, '0, r);
        drain();
    endtask

    task automatic test_contention();
        logic [1:0] r;
        logic [1:0] want;
        step(2'b10, 2'b00, 8'h00, 8'h10, '0, '0, r);
        for (int i = 0; i < 6; i++) begin
            step(2'b11, 2'b00, 8'h20, 8'h21, '0, '0, r);
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_checks++;
            if (r !== want) begin
                n_fail++;
                $display("FAIL contention_seq[%0d]: got %b, required %b", i, r, want);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [1:0] r;
        step(2'b11, 2'b10, 8'h30, 8'hFF, '0, 48'hAAAA, r);
        n_checks++;
        if (r !== 2'b01) begin
            n_fail++;
            $display("FAIL hold_first: got %b, required 01", r);
        end
        step(2'b10, 2'b10, 8'h30, 8'hFF, '0, 48'hAAAA, r);
        n_checks++;
        if (r !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_second: got %b, required 10", r);
        end
        step(2'b01, 2'b00, 8'hFF, 8'h00, '0, '0, r);
        drain();
    endtask

    task automatic test_mid_scrub_reset();
        logic [1:0] r;
        int n;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (bank_address !== 8'd100 && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (bank_address !== 8'd100) begin
            n_fail++;
            $display("FAIL midreset_wait: bank_address=%h after %0d cycles, required 64", bank_address, n);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({init_done, req_ready, rsp_valid, rsp_id, bank_banksel, bank_read, bank_write, bank_address, bank_wd} !== '0) begin
            n_fail++;
            $display("FAIL midreset_values: init=%b ready=%b rv=%b id=%b sel=%b rd=%b wr=%b addr=%h wd=%h, required all 0",
                     init_done, req_ready, rsp_valid, rsp_id, bank_banksel, bank_read, bank_write, bank_address, bank_wd);
        end
        @(negedge clk);
        run_scrub("rescrub");
        step(2'b10, 2'b00, 8'h00, 8'hFF, '0, '0, r);
        drain();
    endtask

    task automatic test_raw();
        logic [1:0] r;
        step(2'b01, 2'b01, 8'hFF, 8'h00, 48'h5, '0, r);
        step(2'b01, 2'b00, 8'hFF, 8'h00, '0, '0, r);
        step(2'b01, 2'b00, 8'h00, 8'h00, '0, '0, r);
        drain();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_scrub_read();
        test_write_read();
        test_contention();
        test_backpressure();
        test_mid_scrub_reset();
        test_raw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
